// File: rtl/frame_slicer.sv
// Frame slicer: captures one message frame and one received-codeword frame, then streams
// message bits to the encoder and code-symbol groups to the decoder on independent channels.
module frame_slicer #(
  parameter int MSG_LEN      = 128,
  parameter int SYM_PER_BEAT = 2,
  parameter int MAX_N        = 3,
  parameter int DEC_W        = MAX_N * MSG_LEN,
  parameter int RX_W         = MAX_N * SYM_PER_BEAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_code_rate,
  input  logic               i_load,
  output logic               o_load_ready,
  input  logic               i_flush,
  input  logic [MSG_LEN-1:0] i_encoder_data_frame,
  input  logic [DEC_W-1:0]   i_decoder_data_frame,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_tx_data,
  output logic               o_tx_last,
  output logic               o_rx_valid,
  input  logic               i_rx_ready,
  output logic [RX_W-1:0]    o_rx_data,
  output logic               o_rx_last,
  output logic               o_busy,
  output logic               o_done
);

  localparam int TXP_W = $clog2(MSG_LEN);
  localparam int RXP_W = $clog2(DEC_W);
  localparam int STEP2 = 2 * SYM_PER_BEAT;
  localparam int STEP3 = 3 * SYM_PER_BEAT;

  typedef enum logic {IDLE, RUN} state_e;

  // Valid/ready: a beat transfers on a cycle where valid && ready; while valid && !ready
  // the beat (data/last) is held unchanged. Valid never drops without a handshake except on flush.
  state_e             state_q, state_d;
  logic [MSG_LEN-1:0] enc_q, enc_d;
  logic [DEC_W-1:0]   dec_q, dec_d;
  logic               rate_q, rate_d;
  logic [TXP_W-1:0]   tx_ptr_q, tx_ptr_d;
  logic [RXP_W-1:0]   rx_ptr_q, rx_ptr_d;
  logic               tx_valid_q, tx_valid_d;
  logic               rx_valid_q, rx_valid_d;
  logic               done_q, done_d;

  logic               tx_hs, rx_hs, tx_is_last, rx_is_last, tx_fin, rx_fin;
  logic [RXP_W-1:0]   rx_floor, rx_shamt;
  logic [RX_W-1:0]    rx_win, rx_field;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      enc_q      <= '0;
      dec_q      <= '0;
      rate_q     <= 1'b0;
      tx_ptr_q   <= '0;
      rx_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      enc_q      <= enc_d;
      dec_q      <= dec_d;
      rate_q     <= rate_d;
      tx_ptr_q   <= tx_ptr_d;
      rx_ptr_q   <= rx_ptr_d;
      tx_valid_q <= tx_valid_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    enc_d      = enc_q;
    dec_d      = dec_q;
    rate_d     = rate_q;
    tx_ptr_d   = tx_ptr_q;
    rx_ptr_d   = rx_ptr_q;
    tx_valid_d = tx_valid_q;
    rx_valid_d = rx_valid_q;
    done_d     = 1'b0;

    rx_floor   = rate_q ? RXP_W'(STEP3 - 1) : RXP_W'(STEP2 - 1);
    tx_hs      = tx_valid_q & i_tx_ready;
    rx_hs      = rx_valid_q & i_rx_ready;
    tx_is_last = tx_valid_q && (tx_ptr_q == '0);
    rx_is_last = rx_valid_q && (rx_ptr_q == rx_floor);
    tx_fin     = !tx_valid_q || (tx_hs && tx_is_last);
    rx_fin     = !rx_valid_q || (rx_hs && rx_is_last);

    case (state_q)
      IDLE: begin
        if (i_load) begin
          state_d    = RUN;
          enc_d      = i_encoder_data_frame;
          dec_d      = i_decoder_data_frame;
          rate_d     = i_code_rate;
          tx_ptr_d   = TXP_W'(MSG_LEN - 1);
          rx_ptr_d   = i_code_rate ? RXP_W'(3 * MSG_LEN - 1) : RXP_W'(2 * MSG_LEN - 1);
          tx_valid_d = 1'b1;
          rx_valid_d = 1'b1;
        end
      end
      RUN: begin
        if (tx_hs) begin
          if (tx_is_last) tx_valid_d = 1'b0;
          else            tx_ptr_d   = tx_ptr_q - 1'b1;
        end
        if (rx_hs) begin
          if (rx_is_last) rx_valid_d = 1'b0;
          else            rx_ptr_d   = rx_ptr_q - (rate_q ? RXP_W'(STEP3) : RXP_W'(STEP2));
        end
        if (tx_fin && rx_fin) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_flush) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  // The beat window holds f[p-step+1 .. p]; the pointer floor keeps the shift non-negative.
  always_comb begin
    rx_shamt = (rx_ptr_q >= rx_floor) ? (rx_ptr_q - rx_floor) : '0;
    rx_win   = RX_W'(dec_q >> rx_shamt);
    rx_field = '0;
    if (rate_q) begin
      for (int k = 0; k < SYM_PER_BEAT; k++)
        for (int j = 0; j < 3; j++)
          rx_field[k*MAX_N + j] = rx_win[STEP3 - 1 - 3*k - j];
    end else begin
      for (int k = 0; k < SYM_PER_BEAT; k++)
        for (int j = 0; j < 2; j++)
          rx_field[k*MAX_N + j] = rx_win[STEP2 - 1 - 2*k - j];
    end
  end

  assign o_load_ready = (state_q == IDLE);
  assign o_busy       = (state_q == RUN);
  assign o_done       = done_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_tx_data    = tx_valid_q & enc_q[tx_ptr_q];
  assign o_tx_last    = tx_is_last;
  assign o_rx_valid   = rx_valid_q;
  assign o_rx_data    = rx_valid_q ? rx_field : '0;
  assign o_rx_last    = rx_is_last;

endmodule

// File: tb/tb_frame_slicer.sv
// Directed bench for frame_slicer: golden TX/RX beat model, backpressure, mid-frame
// disturbance, flush and reset aborts.
module tb_frame_slicer;
  localparam int MSG_LEN  = 128;
  localparam int SPB      = 2;
  localparam int MAX_N    = 3;
  localparam int DEC_W    = MAX_N * MSG_LEN;
  localparam int RX_W     = MAX_N * SPB;
  localparam int RX_BEATS = MSG_LEN / SPB;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_code_rate, i_load, i_flush, i_tx_ready, i_rx_ready;
  logic [MSG_LEN-1:0] i_encoder_data_frame;
  logic [DEC_W-1:0]   i_decoder_data_frame;
  logic               o_load_ready, o_tx_valid, o_tx_data, o_tx_last;
  logic               o_rx_valid, o_rx_last, o_busy, o_done;
  logic [RX_W-1:0]    o_rx_data;

  int errors = 0;
  int checks = 0;

  logic [MSG_LEN-1:0] enc_m;
  logic [DEC_W-1:0]   dec_m;
  logic               rate_m;

  frame_slicer #(.MSG_LEN(MSG_LEN), .SYM_PER_BEAT(SPB), .MAX_N(MAX_N)) dut (
    .clk(clk), .rst(rst), .i_code_rate(i_code_rate), .i_load(i_load),
    .o_load_ready(o_load_ready), .i_flush(i_flush),
    .i_encoder_data_frame(i_encoder_data_frame), .i_decoder_data_frame(i_decoder_data_frame),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data), .o_tx_last(o_tx_last),
    .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready), .o_rx_data(o_rx_data), .o_rx_last(o_rx_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MSG_LEN-1:0] rand_enc();
    logic [MSG_LEN-1:0] v;
    for (int i = 0; i < MSG_LEN / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [DEC_W-1:0] rand_dec();
    logic [DEC_W-1:0] v;
    for (int i = 0; i < DEC_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Symbol k of beat b: bit j is f[p - n*k - j], p = n*MSG_LEN-1 - n*SPB*b.
  function automatic logic [RX_W-1:0] exp_rx(input int b);
    logic [RX_W-1:0] r;
    int n, p;
    r = '0;
    n = rate_m ? 3 : 2;
    p = n * MSG_LEN - 1 - n * SPB * b;
    for (int k = 0; k < SPB; k++)
      for (int j = 0; j < n; j++)
        r[k*MAX_N + j] = dec_m[p - n*k - j];
    return r;
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns #1 after the accept edge.
  task automatic load(input logic rate, input logic [MSG_LEN-1:0] enc, input logic [DEC_W-1:0] dec);
    enc_m = enc;
    dec_m = dec;
    rate_m = rate;
    i_code_rate = rate;
    i_encoder_data_frame = enc;
    i_decoder_data_frame = dec;
    i_load = 1'b1;
    @(posedge clk); #1;
    i_load = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: RX stalls 5 cycles at beat 10, 3: mid-frame disturbance
  task automatic stream(input int mode, output int lat);
    int tx_b, rx_b, n, stall;
    bit fin, hs_tx, hs_rx;
    tx_b = 0; rx_b = 0; n = 0; stall = 0; fin = 0; lat = -1;
    while (!fin && n < 1000) begin
      i_tx_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1)                                i_rx_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && rx_b == 10 && stall < 5) i_rx_ready = 1'b0;
      else                                          i_rx_ready = 1'b1;
      if (mode == 3 && n == 20) begin
        i_load = 1'b1;
        i_code_rate = ~rate_m;
        i_encoder_data_frame = rand_enc();
        i_decoder_data_frame = rand_dec();
      end
      if (mode == 3 && n == 21) begin
        chk("mid_load_ready", o_load_ready, 1'b0);
        i_load = 1'b0;
      end
      if (tx_b < MSG_LEN) begin
        chk("tx_valid", o_tx_valid, 1'b1);
        chk("tx_data", o_tx_data, enc_m[MSG_LEN-1-tx_b]);
        chk("tx_last", o_tx_last, tx_b == MSG_LEN - 1);
      end else begin
        chk("tx_idle", {o_tx_valid, o_tx_data, o_tx_last}, 3'b000);
      end
      if (rx_b < RX_BEATS) begin
        chk("rx_valid", o_rx_valid, 1'b1);
        chk("rx_data", o_rx_data, exp_rx(rx_b));
        chk("rx_last", o_rx_last, rx_b == RX_BEATS - 1);
      end else begin
        chk("rx_idle", {o_rx_valid, o_rx_data, o_rx_last}, 8'h00);
      end
      chk("run_flags", {o_done, o_busy, o_load_ready}, 3'b010);
      hs_tx = i_tx_ready && tx_b < MSG_LEN;
      hs_rx = i_rx_ready && rx_b < RX_BEATS;
      if (mode == 2 && rx_b == 10 && !i_rx_ready) stall++;
      @(posedge clk); #1;
      n++;
      if (hs_tx) tx_b++;
      if (hs_rx) rx_b++;
      if (tx_b == MSG_LEN && rx_b == RX_BEATS) fin = 1;
    end
    i_load = 1'b0;
    if (!fin) begin
      chk("stream_timeout", 1'b0, 1'b1);
    end else begin
      lat = n;
      chk("done_flags", {o_done, o_busy, o_load_ready}, 3'b101);
      chk("done_valids", {o_tx_valid, o_rx_valid}, 2'b00);
      if (mode == 2) chk("stall_len", stall, 5);
      @(posedge clk); #1;
      chk("done_pulse_end", o_done, 1'b0);
    end
    i_tx_ready = 1'b1;
    i_rx_ready = 1'b1;
  endtask

  task automatic abort_test(input bit use_rst);
    int lat;
    load(1'b0, rand_enc(), rand_dec());
    for (int b = 0; b < 40; b++) begin
      chk("abort_pre_tx", o_tx_data, enc_m[MSG_LEN-1-b]);
      @(posedge clk); #1;
    end
    if (use_rst) rst = 1'b0; else i_flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    i_flush = 1'b0;
    chk(use_rst ? "rst_valids" : "flush_valids", {o_tx_valid, o_rx_valid}, 2'b00);
    chk(use_rst ? "rst_data" : "flush_data", {o_tx_data, o_rx_data, o_tx_last, o_rx_last}, 9'h000);
    chk(use_rst ? "rst_flags" : "flush_flags", {o_done, o_busy, o_load_ready}, 3'b001);
    @(posedge clk); #1;
    chk("abort_no_done", o_done, 1'b0);
    load(1'b1, rand_enc(), rand_dec());
    chk("restart_first_tx", o_tx_data, enc_m[MSG_LEN-1]);
    stream(0, lat);
  endtask

  initial begin
    logic [MSG_LEN-1:0] enc;
    logic [DEC_W-1:0]   dec;
    int lat;
    rst = 1'b0;
    i_code_rate = 1'b0; i_load = 1'b0; i_flush = 1'b0;
    i_tx_ready = 1'b1; i_rx_ready = 1'b1;
    i_encoder_data_frame = '0; i_decoder_data_frame = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", o_load_ready, 1'b1);
    chk("reset_outs", {o_tx_valid, o_tx_data, o_tx_last, o_rx_valid, o_rx_data, o_rx_last, o_busy, o_done},
        14'h0000);
    rst = 1'b1;
    @(posedge clk); #1;

    // Rate 1/2, single bits at both ends of the message frame.
    enc = '0; enc[MSG_LEN-1] = 1'b1; enc[0] = 1'b1;
    load(1'b0, enc, '0);
    chk("t1_first_tx", o_tx_data, 1'b1);
    stream(0, lat);
    chk("t1_done_lat", lat, MSG_LEN);

    // Rate 1/2: upper third set to ones so any leak of f[383:256] would show.
    dec = '0; dec[DEC_W-1:2*MSG_LEN] = '1; dec[255:252] = 4'b1011;
    load(1'b0, rand_enc(), dec);
    chk("t2_first_rx", o_rx_data, 6'h19);
    stream(0, lat);
    chk("t2_done_lat", lat, MSG_LEN);

    // Rate 1/3.
    dec = rand_dec(); dec[383:378] = 6'b110100;
    load(1'b1, rand_enc(), dec);
    chk("t3_first_rx", o_rx_data, 6'h0B);
    stream(0, lat);

    // Backpressure: RX stall at beat 10, then random ready on both channels.
    load(1'b1, rand_enc(), rand_dec());
    stream(2, lat);
    load(1'b0, rand_enc(), rand_dec());
    stream(1, lat);
    load(1'b1, rand_enc(), rand_dec());
    stream(1, lat);

    // Mid-frame load pulse, rate toggle and frame changes.
    load(1'b0, rand_enc(), rand_dec());
    stream(3, lat);
    chk("t5_done_lat", lat, MSG_LEN);

    abort_test(1'b0);
    abort_test(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_slicer.md
Name: frame_slicer

Overview:
Parametrised successor to the codec's frame slicer. Captures one encoder message frame and one received-codeword frame, then streams them out on two independent valid/ready channels. The TX channel carries one message bit per beat to the convolutional encoder. The RX channel carries SYM_PER_BEAT code symbols per beat to the Viterbi decoder, for rate 1/2 or rate 1/3. Adds backpressure, last/done signalling, flush, and rate latched per frame.

Parameters:
MSG_LEN, 128, message bits per frame; must be divisible by SYM_PER_BEAT.
SYM_PER_BEAT, 2, code symbols per RX beat.
MAX_N, 3, max code bits per symbol (rate 1/3).
DEC_W, MAX_N*MSG_LEN (384), decoder frame width.
RX_W, MAX_N*SYM_PER_BEAT (6), RX beat width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
i_code_rate  in  1  0 = rate 1/2, 1 = rate 1/3; sampled only on load accept
i_load  in  1  frame-present request
o_load_ready  out  1  high only in IDLE
i_flush  in  1  synchronous abort
i_encoder_data_frame  in  MSG_LEN  message frame
i_decoder_data_frame  in  DEC_W  received codeword frame
o_tx_valid  out  1  TX beat valid
i_tx_ready  in  1  TX sink ready
o_tx_data  out  1  message bit
o_tx_last  out  1  final TX beat
o_rx_valid  out  1  RX beat valid
i_rx_ready  in  1  RX sink ready
o_rx_data  out  RX_W  code symbols
o_rx_last  out  1  final RX beat
o_busy  out  1  state RUN
o_done  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset (rst=0): state IDLE. All outputs 0 except o_load_ready=1. Frame registers cleared.
- FSM states are IDLE and RUN.
- IDLE -> RUN when i_load && o_load_ready. That cycle captures both frames and i_code_rate into registers, loads the TX pointer to MSG_LEN-1, and loads the RX pointer to 2*MSG_LEN-1 (rate 1/2) or 3*MSG_LEN-1 (rate 1/3).
- Latency: the first TX and RX beats are valid on the cycle after accept.
- Each channel holds its output registers stable while valid && !ready. It advances on valid && ready. The channels are fully independent, and neither stalls the other.
- TX: emits frame bits MSB first, index MSG_LEN-1 down to 0, over MSG_LEN beats. o_tx_last=1 with bit 0.
- RX field layout: symbol k (k=0 is first in time) occupies o_rx_data[k*MAX_N +: MAX_N]. Within a symbol, the highest frame index consumed goes in the field LSB.
  - Rate 1/2, pointer p: field k = {0, f[p-2k-1], f[p-2k]}. Field bit 2 is always 0. Pointer decrements by 2*SYM_PER_BEAT per beat. Consumes f[2*MSG_LEN-1:0].
  - Rate 1/3: field k = {f[p-3k-2], f[p-3k-1], f[p-3k]}. Pointer decrements by 3*SYM_PER_BEAT per beat. Consumes all of f.
  - MSG_LEN/SYM_PER_BEAT beats per frame. o_rx_last=1 on the final beat.
- After a channel's last handshake, its valid drops next cycle and its data and last go to 0.
- Completion: the cycle after both channels have completed their last handshake (same cycle or different cycles), state becomes IDLE, o_done=1 for exactly that cycle, and o_load_ready=1.
- i_load while in RUN is ignored. Changes to i_code_rate or to the frame inputs during RUN have no effect.
- i_flush=1, from any state: the next cycle is IDLE, valids=0, lasts=0, data=0, o_done=0. i_flush has priority over load and over handshakes in the same cycle.
- Reset mid-frame behaves the same as flush. Reset has priority over flush.
- Pointers never underflow. The last-beat logic stops advancing at pointer floor.

Test Plan:
1. Rate 1/2, encoder frame = 128'h8000_..._0001, both readys held 1, load at T -> o_tx_data = 1 at T+1, 0 for the next 126 beats, 1 at T+128 with o_tx_last=1; o_done at T+129.
2. Rate 1/2, decoder frame f[255:252] = 4'b1011, rest 0 -> first RX beat o_rx_data = 6'h19; 64 RX beats total, o_rx_last on the 64th; bits 383:256 never appear.
3. Rate 1/3, f[383:378] = 6'b110100 -> first RX beat o_rx_data = 6'h0B; 64 beats; f[5:0] appears on the last beat.
4. Backpressure: i_rx_ready=0 for 5 cycles at RX beat 10 -> o_rx_data and o_rx_valid stable throughout, TX keeps streaming, o_done only after the delayed RX last handshake; also random ready on both channels matches the golden stream.
5. i_load pulsed and i_code_rate toggled mid-frame -> no re-capture, o_load_ready stays 0, and the output stream is unchanged.
6. i_flush (and separately rst=0) at TX beat 40 -> next cycle: valids 0, data 0, o_load_ready 1, no o_done. A new load then restarts from bit MSG_LEN-1.
